// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory bus, with a
// per-transaction grant lock and a slave timeout that forces completion.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 16
) (
  input  logic        r_clk,
  input  logic        rst_n,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        err,
  output logic        grant
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  state_t          r_state;
  logic            r_g;
  logic            r_last;
  logic            r_err;
  logic [TO_W-1:0] r_cnt;

  logic            w_fin;
  logic            w_mv;
  logic            w_rdy;
  logic [31:0]     w_rd;

  // Completion happens either on s_ready or on the timeout cycle; a slave
  // answering on the timeout cycle wins and is treated as a normal completion.
  assign w_fin = (r_state == BUSY) && (s_ready || (r_cnt == TO_LIM));
  assign w_mv  = r_g ? m1_valid : m0_valid;
  assign w_rdy = w_fin && w_mv;
  assign w_rd  = s_ready ? s_rdata : '1;

  always_ff @(posedge r_clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_g     <= 1'b0;
      r_last  <= 1'b1;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (m0_valid && m1_valid) begin
            r_g     <= ~r_last;
            r_state <= BUSY;
          end else if (m0_valid) begin
            r_g     <= 1'b0;
            r_state <= BUSY;
          end else if (m1_valid) begin
            r_g     <= 1'b1;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_fin) begin
            r_last  <= r_g;
            r_err   <= ~s_ready;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_valid  = (r_state == BUSY);
  assign s_addr   = r_g ? m1_addr  : m0_addr;
  assign s_wdata  = r_g ? m1_wdata : m0_wdata;
  assign s_wstrb  = r_g ? m1_wstrb : m0_wstrb;

  // A granted master that dropped valid mid-transaction gets no ready strobe.
  assign m0_ready = w_rdy && !r_g;
  assign m1_ready = w_rdy &&  r_g;
  assign m0_rdata = (w_rdy && !r_g) ? w_rd : '0;
  assign m1_rdata = (w_rdy &&  r_g) ? w_rd : '0;

  assign err   = r_err;
  assign grant = r_g;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: master request queues, a latency-
// programmable slave, and a completion scoreboard per master.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned TO = 4;

  logic        r_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic        s_ready = 1'b0;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata = '0;
  logic        err, grant;

  always #5 r_clk = ~r_clk;

  mem_arbiter #(.TIMEOUT(TO), .TO_W(16)) dut (
    .r_clk(r_clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .err(err), .grant(grant)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    bit          to;
    int          lat;
  } item_t;

  item_t reqq0[$], reqq1[$], expq0[$], expq1[$];
  int    glog[$];
  item_t it0, it1, em;
  int    nchk = 0, nerr = 0;
  int    slat = 1, scnt = 0, mcnt = 0;
  bit    act0 = 0, act1 = 0, done0 = 0, done1 = 0, pend_err = 0;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_0000) + 32'h0000_1111);
  endfunction

  function automatic item_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    item_t r;
    r.addr = a; r.wdata = d; r.wstrb = s; r.rdata = '0; r.to = 0; r.lat = 0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected result is fixed when the request is driven, from the slave latency in force.
  always @(posedge r_clk) begin
    #1;
    if (!rst_n) begin
      m0_valid = 0; act0 = 0; done0 = 0; reqq0.delete(); expq0.delete();
    end else begin
      if (act0 && done0) begin act0 = 0; done0 = 0; end
      if (!act0 && reqq0.size() != 0) begin
        it0 = reqq0.pop_front();
        m0_addr = it0.addr; m0_wdata = it0.wdata; m0_wstrb = it0.wstrb; m0_valid = 1;
        it0.to = (slat > int'(TO));
        it0.rdata = it0.to ? 32'hFFFFFFFF : slave_data(it0.addr);
        it0.lat = it0.to ? int'(TO) : slat;
        expq0.push_back(it0);
        act0 = 1;
      end else if (!act0) m0_valid = 0;
    end
  end

  always @(posedge r_clk) begin
    #1;
    if (!rst_n) begin
      m1_valid = 0; act1 = 0; done1 = 0; reqq1.delete(); expq1.delete();
    end else begin
      if (act1 && done1) begin act1 = 0; done1 = 0; end
      if (!act1 && reqq1.size() != 0) begin
        it1 = reqq1.pop_front();
        m1_addr = it1.addr; m1_wdata = it1.wdata; m1_wstrb = it1.wstrb; m1_valid = 1;
        it1.to = (slat > int'(TO));
        it1.rdata = it1.to ? 32'hFFFFFFFF : slave_data(it1.addr);
        it1.lat = it1.to ? int'(TO) : slat;
        expq1.push_back(it1);
        act1 = 1;
      end else if (!act1) m1_valid = 0;
    end
  end

  always @(posedge r_clk) begin
    #1;
    if (s_valid) begin
      s_ready = (scnt == slat);
      s_rdata = s_ready ? slave_data(s_addr) : 32'hBAD0BAD0;
      scnt++;
    end else begin
      scnt = 0; s_ready = 0; s_rdata = 32'hBAD0BAD0;
    end
  end

  always @(negedge r_clk) begin
    if (!rst_n) begin
      pend_err = 0; mcnt = 0;
    end else begin
      chk("err", {31'b0, err}, {31'b0, pend_err});
      pend_err = 0;
      if (m0_ready) begin
        if (expq0.size() == 0) chk("spurious_m0_ready", {31'b0, m0_ready}, 32'd0);
        else begin
          em = expq0.pop_front();
          chk("m0_rdata", m0_rdata, em.rdata);
          chk("m0_s_addr", s_addr, em.addr);
          chk("m0_s_wdata", s_wdata, em.wdata);
          chk("m0_s_wstrb", {28'b0, s_wstrb}, {28'b0, em.wstrb});
          chk("m0_latency", mcnt, em.lat);
          chk("m0_grant", {31'b0, grant}, 32'd0);
          chk("m1_ready_while_m0", {31'b0, m1_ready}, 32'd0);
          chk("m1_rdata_while_m0", m1_rdata, 32'd0);
          glog.push_back(0); pend_err = em.to; done0 = 1;
        end
      end
      if (m1_ready) begin
        if (expq1.size() == 0) chk("spurious_m1_ready", {31'b0, m1_ready}, 32'd0);
        else begin
          em = expq1.pop_front();
          chk("m1_rdata", m1_rdata, em.rdata);
          chk("m1_s_addr", s_addr, em.addr);
          chk("m1_s_wdata", s_wdata, em.wdata);
          chk("m1_s_wstrb", {28'b0, s_wstrb}, {28'b0, em.wstrb});
          chk("m1_latency", mcnt, em.lat);
          chk("m1_grant", {31'b0, grant}, 32'd1);
          chk("m0_ready_while_m1", {31'b0, m0_ready}, 32'd0);
          chk("m0_rdata_while_m1", m0_rdata, 32'd0);
          glog.push_back(1); pend_err = em.to; done1 = 1;
        end
      end
      mcnt = s_valid ? mcnt + 1 : 0;
    end
  end

  function automatic int pending();
    return reqq0.size() + reqq1.size() + expq0.size() + expq1.size() + int'(act0) + int'(act1);
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    while (pending() != 0 && n < 300) begin
      @(negedge r_clk); n++;
    end
    chk(tag, pending(), 32'd0);
    repeat (2) @(negedge r_clk);
  endtask

  task automatic chk_seq(input string tag, input int n, input logic [7:0] seq);
    chk({tag, "_count"}, glog.size(), n);
    for (int k = 0; k < n && k < glog.size(); k++)
      chk($sformatf("%s_grant%0d", tag, k), glog[k], {31'b0, seq[k]});
    glog.delete();
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(negedge r_clk);
    rst_n = 1;
    @(negedge r_clk);
    glog.delete();
  endtask

  initial begin
    int n;
    repeat (3) @(negedge r_clk);
    chk("rst_s_valid", {31'b0, s_valid}, 32'd0);
    chk("rst_m0_ready", {31'b0, m0_ready}, 32'd0);
    chk("rst_m1_ready", {31'b0, m1_ready}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_grant", {31'b0, grant}, 32'd0);
    rst_n = 1;
    @(negedge r_clk);

    slat = 2;
    reqq0.push_back(mk(32'h10, 32'h0, 4'h0));
    drain("t1_drain");
    chk_seq("t1", 1, 8'b0);

    do_reset();
    slat = 1;
    reqq0.push_back(mk(32'h4, 32'h0, 4'h0));
    reqq1.push_back(mk(32'h8, 32'h12345678, 4'hF));
    drain("t2_drain");
    chk_seq("t2", 2, 8'b10);

    slat = 0;
    for (int k = 0; k < 3; k++) begin
      reqq0.push_back(mk(32'h100 + 32'(k * 4), 32'h0, 4'h0));
      reqq1.push_back(mk(32'h200 + 32'(k * 4), 32'hA000 + 32'(k), 4'h3));
    end
    drain("t3_drain");
    chk_seq("t3", 6, 8'b0010_1010);

    slat = 100;
    reqq1.push_back(mk(32'h20, 32'h0, 4'h0));
    drain("t4_drain");
    chk_seq("t4", 1, 8'b1);
    slat = 1;
    reqq1.push_back(mk(32'h24, 32'h0, 4'h0));
    drain("t4b_drain");
    chk_seq("t4b", 1, 8'b1);

    slat = int'(TO);
    reqq0.push_back(mk(32'h30, 32'h0, 4'h0));
    drain("t5_drain");
    chk_seq("t5", 1, 8'b0);

    slat = 100;
    reqq0.push_back(mk(32'h40, 32'h0, 4'h0));
    n = 0;
    while (!s_valid && n < 20) begin @(negedge r_clk); n++; end
    chk("t6_busy", {31'b0, s_valid}, 32'd1);
    rst_n = 0;
    @(negedge r_clk);
    chk("t6_rst_s_valid", {31'b0, s_valid}, 32'd0);
    chk("t6_rst_m0_ready", {31'b0, m0_ready}, 32'd0);
    chk("t6_rst_err", {31'b0, err}, 32'd0);
    rst_n = 1;
    @(negedge r_clk);
    glog.delete();
    slat = 1;
    reqq0.push_back(mk(32'h50, 32'h0, 4'h0));
    reqq1.push_back(mk(32'h54, 32'h0, 4'h0));
    drain("t6_drain");
    chk_seq("t6", 2, 8'b10);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", nerr, nchk);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter for the native valid/ready memory bus used by the picorv32 core.
- Shares the single SRAM/MMIO decode port between the CPU core (master 0) and a secondary bus master (master 1), e.g. a SPI-flash boot loader or a UART debug/DMA engine.
- Round-robin fairness with a per-transaction grant lock.
- Bus timeout: a stalled slave cannot hang the SoC, and the timeout is reported on err.

Parameters:
- TIMEOUT, 255, cycles a granted transaction may wait for s_ready before forced completion. Legal range 1..65535.
- TO_W, 16, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- r_clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- m0_valid  in  1  master 0 request
- m0_ready  out  1  master 0 completion strobe
- m0_addr  in  32  master 0 byte address
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte strobes; 0000 means read
- m0_rdata  out  32  master 0 read data
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same as the m0_* ports, for master 1
- s_valid  out  1  slave request
- s_ready  in  1  slave completion
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_wstrb  out  4  slave byte strobes
- s_rdata  in  32  slave read data
- err  out  1  one-cycle pulse when a transaction is completed by timeout
- grant  out  1  index of the currently or last granted master

Behaviour:
- Reset is rst_n, synchronous, active-low, sampled on r_clk.
- Reset state and outputs:
  - state=IDLE, last=1 (so master 0 wins first contention), timeout counter=0.
  - err=0, grant=0, s_valid=0, m0_ready=0, m1_ready=0.
- States:
  - IDLE: no grant held.
  - BUSY: grant g locked.
  - DONE: one-cycle turnaround.
- IDLE:
  - Only m0_valid: latch g=0, go to BUSY. Only m1_valid: latch g=1, go to BUSY.
  - Both valid: g = ~last, go to BUSY.
  - Neither valid: stay in IDLE.
  - s_ready is ignored in IDLE.
- BUSY:
  - s_valid=1; s_addr, s_wdata and s_wstrb are combinationally muxed from master g.
  - s_ready=1: mg_ready=1 in the same cycle; mg_rdata=s_rdata; last<=g; go to DONE.
  - Otherwise counter increments.
  - When counter==TIMEOUT and s_ready=0: mg_ready=1 and mg_rdata=32'hFFFFFFFF in that cycle; err<=1 (one-cycle pulse, next cycle); last<=g; go to DONE.
  - s_ready arriving on the TIMEOUT cycle counts as normal completion; err stays 0.
- DONE:
  - s_valid=0, all m*_ready=0, counter cleared, go to IDLE.
  - This gives masters one cycle to drop valid; minimum spacing is 3 cycles per transaction.
- The non-granted master always sees ready=0 and rdata=0; its request waits with no time limit.
- The granted master dropping valid during BUSY is a protocol violation. The arbiter holds the grant, keeps s_valid high until completion, and discards the ready strobe.
- Latency:
  - Grant appears 1 cycle after valid is seen in IDLE.
  - With a slave ready latency of L cycles, completion comes L cycles after entering BUSY.
- Reset mid-transaction: returns to IDLE immediately; no ready is issued; the slave must also be reset.
- grant output = g register; it holds its value through DONE and IDLE.

Test Plan:
- Master 0 alone reads 0x00000010; slave answers s_rdata=0xDEADBEEF after 2 cycles -> m0_ready for 1 cycle with m0_rdata=0xDEADBEEF; s_wstrb=0000; m1_ready stays 0.
- m0 and m1 both valid in the same cycle after reset (m0 read 0x4, m1 write 0x8 with wdata 0x12345678, wstrb 1111) -> m0 served first, then m1; s_addr=0x8, s_wdata=0x12345678, s_wstrb=1111 during m1's BUSY.
- Both masters held valid continuously for 6 transactions -> grant sequence 0,1,0,1,0,1; no master served twice in a row.
- With TIMEOUT=4 and s_ready tied 0, m1 reads -> m1_ready 4 cycles after BUSY entry with m1_rdata=0xFFFFFFFF; err pulses once; the next request is granted normally.
- s_ready asserted exactly on the TIMEOUT cycle -> normal completion with slave data; err=0.
- rst_n=0 mid-BUSY (m0 granted, slave stalled) -> next cycle state IDLE, s_valid=0, m0_ready never asserted; then with both masters valid, m0 is granted first.
